// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse key timer and the letter decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        STUCK = 2'd3
    } state_t;

    localparam logic        SYM_DOT   = 1'b1;
    localparam logic        SYM_DASH  = 1'b0;
    localparam int unsigned MAX_SYMS  = 4;
    localparam int unsigned SYM_CNT_W = 3;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debounce filter.
module morse_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic key_db
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_key_db;
    logic [DB_W-1:0] r_db_cnt;

    // The debounced level flips on the DB_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_key_db <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_key_db) begin
                if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
                    r_key_db <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign key_db = r_key_db;

endmodule

// File: rtl/morse_key_timer.sv
// Measures debounced mark/space durations and emits dot/dash, letter-end and error strobes.
module morse_key_timer
    import morse_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned DOT_MAX    = 200,
    parameter int unsigned LETTER_GAP = 600,
    parameter int unsigned STUCK_MAX  = 4000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key,
    output logic                 sym_valid,
    output logic                 sym,
    output logic                 letter_end,
    output logic                 err,
    output logic [SYM_CNT_W-1:0] sym_cnt,
    output logic                 busy
);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sym_valid;
    logic                  r_sym;
    logic                  r_letter_end;
    logic                  r_err;
    logic [SYM_CNT_W-1:0]  r_sym_cnt;
    logic                  r_busy;
    logic                  w_key_db;
    logic [CNT_W-1:0]      w_cnt_inc;

    morse_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .key    (key),
        .key_db (w_key_db)
    );

    // Saturating increment so a long run can never wrap the duration counter.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sym_valid  <= 1'b0;
            r_sym        <= 1'b0;
            r_letter_end <= 1'b0;
            r_err        <= 1'b0;
            r_sym_cnt    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_sym_valid  <= 1'b0;
            r_letter_end <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_key_db) begin
                        r_state <= MARK;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                MARK: begin
                    if (w_key_db) begin
                        if (w_cnt_inc == CNT_W'(STUCK_MAX)) begin
                            r_state   <= STUCK;
                            r_err     <= 1'b1;
                            r_sym_cnt <= '0;
                        end
                        r_cnt <= w_cnt_inc;
                    end else begin
                        r_state <= SPACE;
                        r_cnt   <= CNT_W'(1);
                        // Symbols past MAX_SYMS are dropped and flagged; the letter carries on.
                        if (r_sym_cnt < SYM_CNT_W'(MAX_SYMS)) begin
                            r_sym_valid <= 1'b1;
                            r_sym       <= (r_cnt <= CNT_W'(DOT_MAX)) ? SYM_DOT : SYM_DASH;
                            r_sym_cnt   <= r_sym_cnt + SYM_CNT_W'(1);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    r_busy <= 1'b1;
                end
                SPACE: begin
                    if (w_key_db) begin
                        r_state <= MARK;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end else if (w_cnt_inc == CNT_W'(LETTER_GAP)) begin
                        r_state      <= IDLE;
                        r_cnt        <= '0;
                        r_letter_end <= 1'b1;
                        r_sym_cnt    <= '0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_busy <= 1'b1;
                    end
                end
                STUCK: begin
                    if (!w_key_db) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sym_valid  = r_sym_valid;
    assign sym        = r_sym;
    assign letter_end = r_letter_end;
    assign err        = r_err;
    assign sym_cnt    = r_sym_cnt;
    assign busy       = r_busy;

endmodule
